// File: rtl/pipe_stage_buf.sv
// One pipeline-stage register with a valid/ready handshake, flush and bubble gating.
// SKID=1 adds a second entry so that ready_o comes straight from a flop.
module pipe_stage_buf #(
   parameter int unsigned CTRL_W = 4,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned SKID   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] rd_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] rd_o,
   output logic [1:0]        occ_o,
   output logic [7:0]        drop_cnt_o
);

   logic              m_vld_q, m_vld_d, s_vld_q, s_vld_d;
   logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
   logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
   logic [ADDR_W-1:0] m_rd_q, m_rd_d, s_rd_q, s_rd_d;
   logic [7:0]        drop_q, drop_d;
   logic [8:0]        drop_sum;
   logic              in_fire, out_fire;

   assign ready_o  = (SKID != 0) ? !s_vld_q : (!m_vld_q || ready_i);
   assign in_fire  = valid_i && ready_o;
   assign out_fire = m_vld_q && ready_i;

   assign valid_o    = m_vld_q;
   assign ctrl_o     = m_vld_q ? m_ctrl_q : '0;
   assign rd_o       = m_vld_q ? m_rd_q : '0;
   assign data_o     = m_data_q;
   assign occ_o      = {1'b0, m_vld_q} + {1'b0, s_vld_q};
   assign drop_cnt_o = drop_q;

   // occ_o >= out_fire always, so the sum cannot underflow
   assign drop_sum = {1'b0, drop_q} + {7'd0, occ_o} + {8'd0, in_fire} - {8'd0, out_fire};

   always_comb begin
      m_vld_d  = m_vld_q;
      m_ctrl_d = m_ctrl_q;
      m_data_d = m_data_q;
      m_rd_d   = m_rd_q;
      s_vld_d  = s_vld_q;
      s_ctrl_d = s_ctrl_q;
      s_data_d = s_data_q;
      s_rd_d   = s_rd_q;
      drop_d   = drop_q;
      if (flush_i) begin
         m_vld_d  = 1'b0;
         m_ctrl_d = '0;
         s_vld_d  = 1'b0;
         s_ctrl_d = '0;
         drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end else if (!m_vld_q || out_fire) begin
         // head is free this cycle: refill from skid first to keep order
         if (s_vld_q) begin
            m_vld_d  = 1'b1;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            m_rd_d   = s_rd_q;
            s_vld_d  = 1'b0;
         end else if (in_fire) begin
            m_vld_d  = 1'b1;
            m_ctrl_d = ctrl_i;
            m_data_d = data_i;
            m_rd_d   = rd_i;
         end else begin
            m_vld_d  = 1'b0;
         end
      end else if (in_fire && SKID != 0) begin
         s_vld_d  = 1'b1;
         s_ctrl_d = ctrl_i;
         s_data_d = data_i;
         s_rd_d   = rd_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_vld_q  <= 1'b0;
         m_ctrl_q <= '0;
         m_data_q <= '0;
         m_rd_q   <= '0;
         s_vld_q  <= 1'b0;
         s_ctrl_q <= '0;
         s_data_q <= '0;
         s_rd_q   <= '0;
         drop_q   <= '0;
      end else begin
         m_vld_q  <= m_vld_d;
         m_ctrl_q <= m_ctrl_d;
         m_data_q <= m_data_d;
         m_rd_q   <= m_rd_d;
         s_vld_q  <= s_vld_d;
         s_ctrl_q <= s_ctrl_d;
         s_data_q <= s_data_d;
         s_rd_q   <= s_rd_d;
         drop_q   <= drop_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1 instance and a SKID=0 instance.
module tb_pipe_stage_buf;

   logic        clk, rst;
   // SKID=1 instance
   logic        flush, vin, rdy_in, rdy_out, vout;
   logic [3:0]  ctrl, ctrl_out;
   logic [63:0] data, data_out;
   logic [4:0]  rd, rd_out;
   logic [1:0]  occ;
   logic [7:0]  drop;
   // SKID=0 instance
   logic        flush0, vin0, rdy_in0, rdy_out0, vout0;
   logic [3:0]  ctrl0, ctrl_out0;
   logic [63:0] data0, data_out0;
   logic [4:0]  rd0, rd_out0;
   logic [1:0]  occ0;
   logic [7:0]  drop0;

   int n_chk = 0;
   int n_err = 0;

   pipe_stage_buf #(.CTRL_W(4), .DATA_W(64), .ADDR_W(5), .SKID(1)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(rdy_out),
      .ctrl_i(ctrl), .data_i(data), .rd_i(rd), .valid_o(vout), .ready_i(rdy_in),
      .ctrl_o(ctrl_out), .data_o(data_out), .rd_o(rd_out), .occ_o(occ), .drop_cnt_o(drop)
   );

   pipe_stage_buf #(.CTRL_W(4), .DATA_W(64), .ADDR_W(5), .SKID(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush0), .valid_i(vin0), .ready_o(rdy_out0),
      .ctrl_i(ctrl0), .data_i(data0), .rd_i(rd0), .valid_o(vout0), .ready_i(rdy_in0),
      .ctrl_o(ctrl_out0), .data_o(data_out0), .rd_o(rd_out0), .occ_o(occ0),
      .drop_cnt_o(drop0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 0; vin = 0; rdy_in = 0; ctrl = 0; data = 0; rd = 0;
      flush0 = 0; vin0 = 0; rdy_in0 = 0; ctrl0 = 0; data0 = 0; rd0 = 0;
      step(); step();
      rst = 1'b0;
      check("rst_valid", 64'(vout), 64'd0);
      check("rst_ctrl", 64'(ctrl_out), 64'd0);
      check("rst_data", data_out, 64'd0);
      check("rst_occ", 64'(occ), 64'd0);
      check("rst_ready", 64'(rdy_out), 64'd1);
      check("rst_drop", 64'(drop), 64'd0);

      // streaming, last beat carries ctrl=F
      rdy_in = 1; vin = 1;
      for (int i = 1; i <= 8; i++) begin
         data = 64'(i); rd = 5'(i); ctrl = (i == 8) ? 4'hF : 4'h5;
         step();
         check("str_data", data_out, 64'(i));
         check("str_ctrl", 64'(ctrl_out), (i == 8) ? 64'hF : 64'h5);
         check("str_rd", 64'(rd_out), 64'(i));
         check("str_occ", 64'(occ), 64'd1);
         check("str_ready", 64'(rdy_out), 64'd1);
      end
      vin = 0;
      step();
      check("bub_valid", 64'(vout), 64'd0);
      check("bub_ctrl", 64'(ctrl_out), 64'd0);
      check("bub_rd", 64'(rd_out), 64'd0);
      check("bub_data", data_out, 64'd8);
      check("bub_occ", 64'(occ), 64'd0);

      // stall into the skid entry
      rdy_in = 0; vin = 1; data = 64'hA; rd = 5'd1; ctrl = 4'h3;
      step();
      check("stl1_occ", 64'(occ), 64'd1);
      check("stl1_ready", 64'(rdy_out), 64'd1);
      data = 64'hB; rd = 5'd2;
      step();
      check("stl2_occ", 64'(occ), 64'd2);
      check("stl2_ready", 64'(rdy_out), 64'd0);
      check("stl2_data", data_out, 64'hA);
      vin = 0; data = 64'hEE;
      step();
      check("stl3_data", data_out, 64'hA);
      check("stl3_rd", 64'(rd_out), 64'd1);
      check("stl3_occ", 64'(occ), 64'd2);
      rdy_in = 1;
      step();
      check("rel1_data", data_out, 64'hB);
      check("rel1_rd", 64'(rd_out), 64'd2);
      check("rel1_occ", 64'(occ), 64'd1);
      check("rel1_ready", 64'(rdy_out), 64'd1);
      step();
      check("rel2_valid", 64'(vout), 64'd0);
      check("rel2_occ", 64'(occ), 64'd0);

      // flush a full buffer while the head is leaving: 2 held - 1 delivered
      rdy_in = 0; vin = 1; data = 64'hC;
      step();
      data = 64'hD;
      step();
      check("fl_pre_occ", 64'(occ), 64'd2);
      vin = 0; rdy_in = 1; flush = 1;
      step();
      flush = 0;
      check("fl_occ", 64'(occ), 64'd0);
      check("fl_valid", 64'(vout), 64'd0);
      check("fl_drop", 64'(drop), 64'd1);
      // flush with an incoming beat on an empty stage
      vin = 1; rdy_in = 0; flush = 1;
      step();
      flush = 0; vin = 0;
      check("fl_in_drop", 64'(drop), 64'd2);
      check("fl_in_occ", 64'(occ), 64'd0);

      // saturation: each round adds one
      for (int k = 1; k <= 300; k++) begin
         rdy_in = 0; vin = 1;
         step(); step();
         vin = 0; rdy_in = 1; flush = 1;
         step();
         flush = 0;
         if (k == 100) check("sat_mid", 64'(drop), 64'd102);
      end
      check("sat_drop", 64'(drop), 64'd255);
      step();
      check("sat_hold", 64'(drop), 64'd255);

      // asynchronous reset mid-operation
      vin = 1; rdy_in = 0; data = 64'h77;
      step();
      check("ar_pre_occ", 64'(occ), 64'd1);
      vin = 0;
      #2 rst = 1;
      #1;
      check("ar_valid", 64'(vout), 64'd0);
      check("ar_occ", 64'(occ), 64'd0);
      check("ar_ready", 64'(rdy_out), 64'd1);
      check("ar_drop", 64'(drop), 64'd0);
      check("ar_data", data_out, 64'd0);
      #1 rst = 0;

      // SKID=0: combinational ready and full throughput
      step();
      vin0 = 1; rdy_in0 = 0; data0 = 64'h11; ctrl0 = 4'h2; rd0 = 5'd3;
      step();
      check("s0_occ", 64'(occ0), 64'd1);
      check("s0_ready_lo", 64'(rdy_out0), 64'd0);
      data0 = 64'h99;
      step();
      check("s0_hold", data_out0, 64'h11);
      rdy_in0 = 1;
      #1;
      check("s0_ready_hi", 64'(rdy_out0), 64'd1);
      data0 = 64'h12;
      step();
      check("s0_tp1", data_out0, 64'h12);
      check("s0_tp1_occ", 64'(occ0), 64'd1);
      data0 = 64'h13;
      step();
      check("s0_tp2", data_out0, 64'h13);
      vin0 = 0;
      step();
      check("s0_drain", 64'(vout0), 64'd0);
      check("s0_ctrl", 64'(ctrl_out0), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed EX/MEM latch: one pipeline-stage register with a valid/ready handshake and an optional 2-entry skid buffer.
- Supports back-pressure stalls at full throughput, synchronous flush, and bubble control-gating.
- Instanced between any two pipeline stages (ID/EX, EX/MEM, MEM/WB); replaces hard-coded per-stage latches.

Parameters:
- CTRL_W, 4, width of control field (e.g. RegWrite, MemtoReg, MemRead, MemWrite); forced to zero on bubbles.
- DATA_W, 64, width of data payload (e.g. ALU result concatenated with store data); not gated.
- ADDR_W, 5, width of destination register address.
- SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single entry with combinational ready_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush; discards all held and incoming beats.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  stage can accept a beat.
- ctrl_i  in  CTRL_W  upstream control.
- data_i  in  DATA_W  upstream data.
- rd_i  in  ADDR_W  upstream destination register.
- valid_o  out  1  downstream beat valid.
- ready_i  in  1  downstream accepts.
- ctrl_o  out  CTRL_W  control; all zeros whenever valid_o=0.
- data_o  out  DATA_W  data of head entry.
- rd_o  out  ADDR_W  destination register of head entry; 0 when valid_o=0.
- occ_o  out  2  entries held (0..2; max 1 when SKID=0).
- drop_cnt_o  out  8  saturating count of beats discarded by flush.

Behaviour:
- Storage: head entry M (ctrl, data, rd, vld); skid entry S (same fields; present only if SKID=1).
- Handshakes: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Reset (rst_i=1, async): all entry fields and valids = 0. valid_o=0, ctrl_o=0, data_o=0, rd_o=0, occ_o=0, drop_cnt_o=0, ready_o=1.
- Outputs: valid_o = M.vld. ctrl_o = M.vld ? M.ctrl : 0. rd_o = M.vld ? M.rd : 0. data_o = M.data, held when invalid.
- ready_o:
  - SKID=1: ready_o = !S.vld, registered state only; no combinational path from ready_i.
  - SKID=0: ready_o = !M.vld | ready_i.
- Latency: 1 cycle; a beat accepted at edge N is on the outputs after edge N.
- States (SKID=1), with transitions when flush_i=0:
  - EMPTY (occ 0): in_fire -> ONE, M<=in.
  - ONE (occ 1):
    - in_fire & out_fire -> ONE, M<=in.
    - in_fire & !out_fire -> TWO, S<=in.
    - !in_fire & out_fire -> EMPTY.
    - neither -> hold.
  - TWO (occ 2): ready_o=0. out_fire -> ONE, M<=S, S.vld<=0. Otherwise hold.
- SKID=0: states EMPTY and ONE only. In ONE, in_fire is legal only together with out_fire or when M is empty.
- Order: beats leave strictly in acceptance order; no beat is duplicated or lost except by flush.
- Flush (flush_i=1 at an edge), highest priority:
  - Next state is EMPTY; all vld and ctrl fields are cleared.
  - An in_fire in the same cycle is accepted, then discarded.
  - An out_fire in the same cycle counts as delivered.
  - drop_cnt_o += occ_o - out_fire + in_fire, saturating at 255.
- Stall: while valid_o=1 and ready_i=0, ctrl_o, data_o and rd_o stay stable. Inputs are don't-care when valid_i=0.
- Reset mid-operation: immediate clear regardless of clock; handshakes in flight are lost and are not counted in drop_cnt_o.
- drop_cnt_o saturates at 255 and is not cleared by flush, only by reset.

Test Plan:
- Reset: assert rst_i between edges -> valid_o=0, ctrl_o=0, occ_o=0, ready_o=1 without waiting for a clock edge.
- Streaming: ready_i=1, valid_i=1 for 8 cycles, data_i=1..8 -> data_o=1..8 one cycle later, occ_o stays 1, ready_o stays 1.
- Stall with SKID=1:
  - data_i=0xA then 0xB with ready_i=0 -> occ_o=2, ready_o=0, data_o holds 0xA.
  - Release ready_i -> 0xA then 0xB delivered, ready_o=1 after 0xB's predecessor leaves.
- Bubble gating: after the final beat with ctrl_i=4'hF drains -> ctrl_o=0, rd_o=0, data_o holds last value.
- Flush: occ_o=2, ready_i=1, flush_i=1, no in_fire -> next cycle occ_o=0, drop_cnt_o=1. Repeat 300 times with full buffer -> drop_cnt_o saturates at 255.
- SKID=0 build, ready_i=0 with M full -> ready_o=0 combinationally; raise ready_i -> ready_o=1 in the same cycle, throughput 1 beat/cycle.
